// File: rtl/bist_pkg.sv
// Shared definitions for the RAM BIST pattern datapath: mode and FSM encodings,
// maximal-length Galois LFSR tap masks and a constant-evaluable clog2.
package bist_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_WALK1   = 2'd2,
        MODE_LFSR    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int LFSR_MIN_W = 3;
    localparam int LFSR_MAX_W = 16;

    // Right-shift Galois toggle masks; each gives a 2^W-1 cycle over non-zero states.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0006;
        endcase
        return taps;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (value > (1 << i)) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois right-shift LFSR with synchronous load of the seed and single-step advance.
// next_o is the value the register takes at the coming edge.
module lfsr_core
    import bist_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH-1:0] SEED_RAW = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] SEED_W   = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;
    localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

    logic [WIDTH-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SEED_W;
        end else if (step_i) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
        end
    end

    assign next_o = state_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_W;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pattern_gen.sv
// BIST test-pattern generator: SOLID / CHECKER / WALK1 / LFSR sequences with optional
// inversion, start/advance handshake, registered word/valid/last/idx and sticky done.
module pattern_gen
    import bist_pkg::*;
#(
    parameter  int WORD_SIZE = 3,
    parameter  int LFSR_LEN  = 7,
    parameter  int LFSR_SEED = 1,
    localparam int MAX_LEN   = (LFSR_LEN > WORD_SIZE) ? ((LFSR_LEN > 2) ? LFSR_LEN : 2)
                                                      : ((WORD_SIZE > 2) ? WORD_SIZE : 2),
    localparam int IDX_W     = clog2(MAX_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 invert,
    input  logic                 gen_next,
    output logic [WORD_SIZE-1:0] word,
    output logic                 valid,
    output logic                 last,
    output logic [IDX_W-1:0]     idx,
    output logic                 done
);

    function automatic logic [WORD_SIZE-1:0] checker_base();
        logic [WORD_SIZE-1:0] r;
        r = '0;
        for (int k = 0; k < WORD_SIZE; k++) r[k] = ((k % 2) == 1);
        return r;
    endfunction

    localparam logic [WORD_SIZE-1:0] CHECKER_BASE = checker_base();

    function automatic logic [IDX_W-1:0] seq_last(input mode_e m);
        logic [IDX_W-1:0] r;
        r = IDX_W'(1);
        case (m)
            MODE_SOLID, MODE_CHECKER: r = IDX_W'(1);
            MODE_WALK1:               r = IDX_W'(WORD_SIZE - 1);
            MODE_LFSR:                r = IDX_W'(LFSR_LEN - 1);
            default:                  r = IDX_W'(1);
        endcase
        return r;
    endfunction

    function automatic logic [WORD_SIZE-1:0] pattern_word(input mode_e m,
                                                          input logic [IDX_W-1:0] i,
                                                          input logic [WORD_SIZE-1:0] lfsr_val);
        logic [WORD_SIZE-1:0] r;
        r = '0;
        case (m)
            MODE_SOLID:   r = {WORD_SIZE{i[0]}};
            MODE_CHECKER: r = CHECKER_BASE ^ {WORD_SIZE{i[0]}};
            MODE_WALK1:   r = WORD_SIZE'(1) << i;
            MODE_LFSR:    r = lfsr_val;
            default:      r = '0;
        endcase
        return r;
    endfunction

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic                 invert_q, invert_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_SIZE-1:0] word_q, word_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;
    logic [WORD_SIZE-1:0] lfsr_next;
    logic                 start_accept;
    logic                 advance;

    // Kept outside the main combinational block so the LFSR feedback path has no block-level loop.
    assign start_accept = start && (state_q != ST_RUN);
    assign advance      = gen_next && (state_q == ST_RUN);

    lfsr_core #(
        .WIDTH (WORD_SIZE),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (start_accept),
        .step_i (advance),
        .next_o (lfsr_next)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        mode_d   = mode_q;
        invert_d = invert_q;
        idx_d    = idx_q;
        word_d   = word_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = done_q;

        if (start_accept) begin
            state_d  = ST_RUN;
            mode_d   = mode_e'(mode);
            invert_d = invert;
            idx_d    = '0;
            word_d   = pattern_word(mode_e'(mode), '0, lfsr_next) ^ {WORD_SIZE{invert}};
            valid_d  = 1'b1;
            last_d   = (seq_last(mode_e'(mode)) == '0);
            done_d   = 1'b0;
        end else if (advance) begin
            if (last_q) begin
                state_d = ST_DONE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                idx_d  = idx_q + 1'b1;
                word_d = pattern_word(mode_q, idx_d, lfsr_next) ^ {WORD_SIZE{invert_q}};
                last_d = (idx_d == seq_last(mode_q));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_SOLID;
            invert_q <= 1'b0;
            idx_q    <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            invert_q <= invert_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign word  = word_q;
    assign valid = valid_q;
    assign last  = last_q;
    assign idx   = idx_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: a 3-bit instance driven from a vector table and
// hand sequences, and an 8-bit instance running the full 255-word LFSR sequence.
module tb_pattern_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       s3 = 1'b0, i3 = 1'b0, g3 = 1'b0;
    logic [1:0] m3 = 2'd0;
    logic [2:0] w3;
    logic       v3, l3, d3;
    logic [2:0] x3;

    logic       s8 = 1'b0, i8 = 1'b0, g8 = 1'b0;
    logic [1:0] m8 = 2'd0;
    logic [7:0] w8;
    logic       v8, l8, d8;
    logic [7:0] x8;

    always #5 clk = ~clk;

    pattern_gen dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (s3),
        .mode     (m3),
        .invert   (i3),
        .gen_next (g3),
        .word     (w3),
        .valid    (v3),
        .last     (l3),
        .idx      (x3),
        .done     (d3)
    );

    pattern_gen #(
        .WORD_SIZE (8),
        .LFSR_LEN  (255),
        .LFSR_SEED (1)
    ) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (s8),
        .mode     (m8),
        .invert   (i8),
        .gen_next (g8),
        .word     (w8),
        .valid    (v8),
        .last     (l8),
        .idx      (x8),
        .done     (d8)
    );

    typedef struct {
        logic [15:0] word;
        logic        valid;
        logic        last;
        logic [7:0]  idx;
        logic        done;
    } exp_t;

    typedef struct {
        logic       st;
        logic [1:0] md;
        logic       inv;
        logic       gn;
        logic [2:0] w;
        logic       v;
        logic       l;
        logic [2:0] i;
        logic       d;
    } vec_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    passed = 0;
    int    total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [15:0] w, input logic v, input logic l,
                                input logic [7:0] i, input logic d);
        exp_t e;
        e.word = w; e.valid = v; e.last = l; e.idx = i; e.done = d;
        return e;
    endfunction

    function automatic logic [15:0] lfsr_model(input logic [15:0] s, input logic [15:0] taps);
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

    // Drives one cycle of stimulus, queues the expected post-edge outputs, then compares.
    task automatic drive(input bit sel8, input logic st, input logic [1:0] md, input logic inv,
                         input logic gn, input exp_t e, input string tag);
        exp_t  got;
        string t;
        @(negedge clk);
        if (sel8) begin
            s8 = st; m8 = md; i8 = inv; g8 = gn;
        end else begin
            s3 = st; m3 = md; i3 = inv; g3 = gn;
        end
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        t   = tag_q.pop_front();
        if (sel8) begin
            check({t, ".word"},  32'(w8), 32'(got.word));
            check({t, ".valid"}, 32'(v8), 32'(got.valid));
            check({t, ".last"},  32'(l8), 32'(got.last));
            check({t, ".idx"},   32'(x8), 32'(got.idx));
            check({t, ".done"},  32'(d8), 32'(got.done));
        end else begin
            check({t, ".word"},  32'(w3), 32'(got.word));
            check({t, ".valid"}, 32'(v3), 32'(got.valid));
            check({t, ".last"},  32'(l3), 32'(got.last));
            check({t, ".idx"},   32'(x3), 32'(got.idx));
            check({t, ".done"},  32'(d3), 32'(got.done));
        end
    endtask

    vec_t        vecs[16];
    bit          seen3[8];
    bit          seen8[256];
    logic [15:0] s;

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0}; // idle
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0}; // gen_next in IDLE
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'd0, 1'b0}; // start+gen_next
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 3'd1, 1'b0};
        vecs[4]  = '{1'b1, 2'd0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 3'd1, 1'b0}; // start in RUN
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 3'd2, 1'b1}; // -> DONE
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 3'd2, 1'b1}; // gen_next in DONE
        vecs[8]  = '{1'b1, 2'd1, 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 3'd0, 1'b0}; // CHECKER inverted
        vecs[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b1, 3'd1, 1'b0}; // mode/inv changed
        vecs[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 3'd1, 1'b1};
        vecs[11] = '{1'b1, 2'd0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0}; // SOLID
        vecs[12] = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 3'd1, 1'b0};
        vecs[13] = '{1'b1, 2'd3, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 3'd1, 1'b1}; // start+gn in RUN
        vecs[14] = '{1'b1, 2'd0, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 3'd0, 1'b0}; // SOLID inverted
        vecs[15] = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 3'd1, 1'b0};

        #12;
        check("reset3.word", 32'(w3), 32'd0);
        check("reset3.valid", 32'(v3), 32'd0);
        check("reset8.word", 32'(w8), 32'd0);
        check("reset8.done", 32'(d8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            drive(1'b0, vecs[k].st, vecs[k].md, vecs[k].inv, vecs[k].gn,
                  mk(16'(vecs[k].w), vecs[k].v, vecs[k].l, 8'(vecs[k].i), vecs[k].d),
                  $sformatf("vec%0d", k));
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(16'h0, 1'b0, 1'b0, 8'd1, 1'b1), "solid_done");

        // LFSR on the 3-bit instance: 7 distinct non-zero words, last on the seventh.
        s = 16'h1;
        drive(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, mk(s, 1'b1, 1'b0, 8'd0, 1'b0), "lfsr3_0");
        check("lfsr3_0.nonzero", 32'(w3 == 3'd0), 32'd0);
        seen3[w3] = 1'b1;
        for (int k = 1; k < 7; k++) begin
            s = lfsr_model(s, 16'h0006);
            drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(s, 1'b1, 1'(k == 6), 8'(k), 1'b0),
                  $sformatf("lfsr3_%0d", k));
            check($sformatf("lfsr3_%0d.nonzero", k), 32'(w3 == 3'd0), 32'd0);
            check($sformatf("lfsr3_%0d.distinct", k), 32'(seen3[w3]), 32'd0);
            seen3[w3] = 1'b1;
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(s, 1'b0, 1'b0, 8'd6, 1'b1), "lfsr3_done");

        // Asynchronous reset in the middle of a WALK1 run.
        drive(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, mk(16'h6, 1'b1, 1'b0, 8'd0, 1'b0), "walk_inv_0");
        drive(1'b0, 1'b0, 2'd2, 1'b0, 1'b1, mk(16'h5, 1'b1, 1'b0, 8'd1, 1'b0), "walk_inv_1");
        @(negedge clk);
        g3 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset.word", 32'(w3), 32'd0);
        check("midreset.valid", 32'(v3), 32'd0);
        check("midreset.last", 32'(l3), 32'd0);
        check("midreset.idx", 32'(x3), 32'd0);
        check("midreset.done", 32'(d3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(16'h0, 1'b0, 1'b0, 8'd0, 1'b0), "postreset_idle");
        drive(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, mk(16'h1, 1'b1, 1'b0, 8'd0, 1'b0), "postreset_walk");
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, mk(16'h1, 1'b1, 1'b0, 8'd0, 1'b0), "postreset_hold");

        // Full 255-word LFSR run on the 8-bit instance.
        s = 16'h1;
        drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, mk(s, 1'b1, 1'b0, 8'd0, 1'b0), "lfsr8_0");
        seen8[w8] = 1'b1;
        for (int k = 1; k < 255; k++) begin
            s = lfsr_model(s, 16'h00B8);
            drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, mk(s, 1'b1, 1'(k == 254), 8'(k), 1'b0),
                  $sformatf("lfsr8_%0d", k));
            check($sformatf("lfsr8_%0d.nonzero", k), 32'(w8 == 8'd0), 32'd0);
            check($sformatf("lfsr8_%0d.distinct", k), 32'(seen8[w8]), 32'd0);
            seen8[w8] = 1'b1;
        end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, mk(s, 1'b0, 1'b0, 8'd254, 1'b1), "lfsr8_done");
        drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, mk(16'h1, 1'b1, 1'b0, 8'd0, 1'b0), "lfsr8_restart");

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
